fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch-sequencing stage that sits directly upstream of the register file and decoder. It produces the instruction address each cycle and gates execution with `InstValid`. It inserts one resolve cycle on every branch (BNE/BGT), because register-file operands and the branch target register are read through a clocked port and arrive one cycle after the branch issues. It also keeps taken-branch and retired-instruction counters for benchmark reporting.

## Interface
- `PCW`, 10, program counter width; instruction memory depth is 2**PCW.
- `W`, 8, data path width; also the width of the branch offset from the register file.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high; overrides every other input.
- `Start`  in  1  begins a program run at PC 0; honoured only in IDLE or DONE.
- `Halt`  in  1  decoded halt instruction at the current PC; sampled only in RUN.
- `Branch`  in  1  decoded BNE/BGT at the current PC; sampled only in RUN.
- `Taken`  in  1  ALU compare result for the pending branch; sampled only in RESOLVE.
- `Target`  in  W  branch offset read from the target register, two's complement; sampled only in RESOLVE.
- `PC`  out  PCW  instruction memory address.
- `InstValid`  out  1  high when the instruction at `PC` executes this cycle; gates RegFile `WriteEn` and data-memory writes.
- `Done`  out  1  program has halted.
- `BranchCount`  out  8  taken branches since the run started; saturates at 255.
- `InstCount`  out  16  instructions retired (cycles with `InstValid`=1) since the run started; saturates at 65535.

## Operation
- States: IDLE, RUN, RESOLVE, DONE. All outputs are functions of registered state only (no input-to-output combinational paths).
- Reset (any state, mid-run included): next state IDLE, `PC`=0, `BranchCount`=0, `InstCount`=0. Outputs after reset: `InstValid`=0, `Done`=0.
- IDLE: `InstValid`=0, `Done`=0, `PC` held.
  - `Start`=1 -> RUN, `PC`<=0, both counters cleared.
- RUN: `InstValid`=1. Each cycle `InstCount` increments (saturating). Priority order:
  - `Halt`=1 -> DONE, `PC` held at the halt address.
  - else `Branch`=1 -> RESOLVE, `PC` held at the branch address.
  - else `PC`<=`PC`+1.
  - `Start` is ignored.
- RESOLVE: `InstValid`=0, `PC` held. `Halt`, `Branch` and `Start` are ignored. Next state is always RUN.
  - `Taken`=1: `PC`<=`PC` + sign-extended `Target`; `BranchCount` increments (saturating).
  - `Taken`=0: `PC`<=`PC`+1.
- DONE: `Done`=1, `InstValid`=0, `PC` and counters held.
  - `Start`=1 -> RUN with `PC`=0, counters cleared, `Done` drops in the next cycle.
- Arithmetic: all `PC` updates are modulo 2**PCW, so `PC`+1 at 1023 wraps to 0 and negative offsets wrap.
- `Target`=0 with `Taken`=1 re-executes the same branch. This is legal and loops indefinitely.
- The halt instruction itself is counted in `InstCount`. The branch instruction is counted once, in its RUN cycle.

## Timing
- `Start` sampled at edge n: `PC`=0 and `InstValid`=1 from cycle n+1.
- Non-branch instruction: 1 cycle per instruction.
- Branch: 2 cycles. Cycle k is the RUN cycle (branch issues, RegFile latches its operands and target). Cycle k+1 is RESOLVE (`Taken`/`Target` valid). The new `PC` appears in cycle k+2.
- `Halt` in cycle k: `Done`=1 from cycle k+1.
- `Reset` at edge n: all reset values are visible in cycle n+1, regardless of `Start`.

## Test plan
- Reset, then `Start` pulse, no branch or halt for 5 cycles -> `PC` sequence 0,1,2,3,4; `InstValid`=1 throughout; `InstCount`=5.
- At `PC`=3 assert `Branch`; next cycle `Taken`=1, `Target`=8'hFE -> `PC` 3,3,1; `InstValid` 1,0,1; `BranchCount`=1.
- At `PC`=5 assert `Branch`; next cycle `Taken`=0, `Target`=8'h10 -> `PC` 5,5,6; `BranchCount` unchanged.
- `PC`=1023 with no branch -> next `PC`=0. Branch at `PC`=1020 with `Target`=8'h07 taken -> `PC`=3.
- `Halt` and `Branch` both high at `PC`=7 -> DONE, `PC` stays 7, `Done`=1, `InstValid`=0. A later `Start` restarts at `PC`=0 with counters at 0.
- `Reset` during RESOLVE with `Taken`=1 -> next cycle IDLE, `PC`=0, counters 0, no branch applied. 256 taken branches -> `BranchCount` holds at 255.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencer feeding the register file
// and decoder. Every branch costs one extra resolve cycle, because its
// operands and target offset come through a clocked register-file port and
// arrive one cycle after the branch issues. The unit also counts taken
// branches and retired instructions for benchmark reporting.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for Start; PC held, nothing executes
//   ST_RUN     | instruction at PC executes; PC advances, halts or branches
//   ST_RESOLVE | branch bubble; Taken/Target valid; PC redirected or +1
//   ST_DONE    | halted at halt address; waiting for Start to rerun
//
// InstValid and Done are decoded from the registered state alone, so no
// input ever reaches an output in the same cycle.

module fetch_unit #(
  parameter int PCW = 10,
  parameter int W   = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Halt,
  input  logic           Branch,
  input  logic           Taken,
  input  logic [W-1:0]   Target,
  output logic [PCW-1:0] PC,
  output logic           InstValid,
  output logic           Done,
  output logic [7:0]     BranchCount,
  output logic [15:0]    InstCount
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [PCW-1:0] pc_next;
  logic [7:0]     branch_count_next;
  logic [15:0]    inst_count_next;

  // Both PC updates wrap modulo 2**PCW simply by dropping the carry out.
  // The branch offset is sign-extended to PC width, so a negative offset
  // wraps backwards past address 0.
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] target_ext;
  logic [PCW-1:0] pc_branch;

  assign pc_inc     = PC + PCW'(1);
  assign target_ext = PCW'($signed(Target));
  assign pc_branch  = PC + target_ext;

  // Both counters stick at all-ones instead of wrapping.
  logic           inst_count_sat;
  logic           branch_count_sat;

  assign inst_count_sat   = (InstCount == 16'hFFFF);
  assign branch_count_sat = (BranchCount == 8'hFF);

  // Next-state and next-datapath decode; values hold unless a case changes them.
  always_comb begin
    state_next        = state;
    pc_next           = PC;
    branch_count_next = BranchCount;
    inst_count_next   = InstCount;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_next        = ST_RUN;
          pc_next           = '0;
          branch_count_next = '0;
          inst_count_next   = '0;
        end
      end

      ST_RUN: begin
        // Every RUN cycle retires an instruction, including a halt or a branch.
        if (!inst_count_sat) begin
          inst_count_next = InstCount + 16'd1;
        end
        if (Halt) begin
          state_next = ST_DONE;
        end else if (Branch) begin
          state_next = ST_RESOLVE;
        end else begin
          pc_next = pc_inc;
        end
      end

      ST_RESOLVE: begin
        state_next = ST_RUN;
        if (Taken) begin
          pc_next = pc_branch;
          if (!branch_count_sat) begin
            branch_count_next = BranchCount + 8'd1;
          end
        end else begin
          pc_next = pc_inc;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, PC and counter registers; Reset wins over every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      PC          <= '0;
      BranchCount <= '0;
      InstCount   <= '0;
    end else begin
      state       <= state_next;
      PC          <= pc_next;
      BranchCount <= branch_count_next;
      InstCount   <= inst_count_next;
    end
  end

  assign InstValid = (state == ST_RUN);
  assign Done      = (state == ST_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit. A behavioural model tracks
// the expected outputs and is compared on every falling edge. Literal
// expectations taken from the hand-worked sequences pin the model as well.

module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Halt;
  logic        Branch;
  logic        Taken;
  logic [7:0]  Target;
  logic [9:0]  PC;
  logic        InstValid;
  logic        Done;
  logic [7:0]  BranchCount;
  logic [15:0] InstCount;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.PCW(10), .W(8)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Halt(Halt),
    .Branch(Branch),
    .Taken(Taken),
    .Target(Target),
    .PC(PC),
    .InstValid(InstValid),
    .Done(Done),
    .BranchCount(BranchCount),
    .InstCount(InstCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model state, kept as plain integers.
  localparam int M_IDLE = 0, M_RUN = 1, M_RES = 2, M_DONE = 3;
  int m_mode  = M_IDLE;
  int m_pc    = 0;
  int m_bc    = 0;
  int m_ic    = 0;
  bit model_on = 1'b0;

  // Model: advance on each rising edge using the inputs held across it.
  initial forever begin
    @(posedge Clk);
    if (Reset === 1'b1) begin
      m_mode = M_IDLE; m_pc = 0; m_bc = 0; m_ic = 0; model_on = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: if (Start) begin
          m_mode = M_RUN; m_pc = 0; m_bc = 0; m_ic = 0;
        end
        M_RUN: begin
          if (m_ic < 65535) m_ic = m_ic + 1;
          if (Halt)        m_mode = M_DONE;
          else if (Branch) m_mode = M_RES;
          else             m_pc = (m_pc + 1) % 1024;
        end
        M_RES: begin
          m_mode = M_RUN;
          if (Taken) begin
            m_pc = (((m_pc + int'($signed(Target))) % 1024) + 1024) % 1024;
            if (m_bc < 255) m_bc = m_bc + 1;
          end else begin
            m_pc = (m_pc + 1) % 1024;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare: DUT outputs against the model on every falling edge after reset.
  initial forever begin
    @(negedge Clk);
    if (model_on) begin
      check("pc",          32'(PC),          32'(m_pc));
      check("inst_valid",  32'(InstValid),   32'(m_mode == M_RUN));
      check("done",        32'(Done),        32'(m_mode == M_DONE));
      check("branch_cnt",  32'(BranchCount), 32'(m_bc));
      check("inst_cnt",    32'(InstCount),   32'(m_ic));
    end
  end

  task automatic drive(input logic rst, input logic st, input logic hl,
                       input logic br, input logic tk, input logic [7:0] tg);
    @(negedge Clk);
    Reset = rst; Start = st; Halt = hl; Branch = br; Taken = tk; Target = tg;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic branch_resolve(input logic tk, input logic [7:0] tg);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, tk, tg);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Branch = 1'b0; Taken = 1'b0; Target = 8'h00;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("lit_reset_pc", 32'(PC), 32'd0);
    check("lit_reset_iv", 32'(InstValid), 32'd0);
    check("lit_reset_done", 32'(Done), 32'd0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("lit_start_pc", 32'(PC), 32'd0);
    check("lit_start_iv", 32'(InstValid), 32'd1);
    idle(3);
    check("lit_seq_pc3", 32'(PC), 32'd3);

    // Taken branch at 3 by -2.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("lit_bubble_pc", 32'(PC), 32'd3);
    check("lit_bubble_iv", 32'(InstValid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE);
    check("lit_taken_pc", 32'(PC), 32'd1);
    check("lit_taken_bc", 32'(BranchCount), 32'd1);

    // Not-taken branch at 5.
    idle(4);
    branch_resolve(1'b0, 8'h10);
    check("lit_nt_pc", 32'(PC), 32'd6);
    check("lit_nt_bc", 32'(BranchCount), 32'd1);
    check("lit_nt_ic", 32'(InstCount), 32'd9);

    // Walk to 1020 and wrap forward and backward.
    branch_resolve(1'b1, 8'h80);
    check("lit_neg_wrap", 32'(PC), 32'd902);
    branch_resolve(1'b1, 8'h76);
    check("lit_pc1020", 32'(PC), 32'd1020);
    branch_resolve(1'b1, 8'h07);
    check("lit_fwd_wrap", 32'(PC), 32'd3);
    branch_resolve(1'b1, 8'hFC);
    check("lit_pc1023", 32'(PC), 32'd1023);
    idle(1);
    check("lit_inc_wrap", 32'(PC), 32'd0);

    // Start in RUN is ignored; then halt and branch together at 7.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("lit_start_ignored", 32'(PC), 32'd1);
    idle(6);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("lit_halt_pc", 32'(PC), 32'd7);
    check("lit_halt_done", 32'(Done), 32'd1);
    check("lit_halt_iv", 32'(InstValid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05);
    idle(1);
    check("lit_done_hold", 32'(PC), 32'd7);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("lit_restart_pc", 32'(PC), 32'd0);
    check("lit_restart_ic", 32'(InstCount), 32'd0);
    check("lit_restart_bc", 32'(BranchCount), 32'd0);
    check("lit_restart_done", 32'(Done), 32'd0);

    // Reset during RESOLVE with a taken branch pending.
    idle(2);
    branch_resolve(1'b1, 8'h04);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
    check("lit_rst_res_pc", 32'(PC), 32'd0);
    check("lit_rst_res_bc", 32'(BranchCount), 32'd0);
    check("lit_rst_res_iv", 32'(InstValid), 32'd0);
    check("lit_rst_res_ic", 32'(InstCount), 32'd0);

    // 256 taken self-branches saturate BranchCount.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) branch_resolve(1'b1, 8'h00);
    check("lit_bc_sat", 32'(BranchCount), 32'd255);
    check("lit_loop_pc", 32'(PC), 32'd0);
    check("lit_loop_ic", 32'(InstCount), 32'd256);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("lit_final_done", 32'(Done), 32'd1);
    check("lit_final_ic", 32'(InstCount), 32'd257);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
